alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Upstream control stage for the register-file/ALU datapath. Accepts 32-bit MIPS R-type instruction words over a valid/ready handshake and decodes rs/rt/rd/shamt/funct. Sequences the register file's one-cycle registered read, the combinational ALU evaluation and the ALU-sourced write-back. Flags add/sub overflow and illegal encodings, and keeps retirement/exception counters.

Parameters:
CNT_W, 16, width of retired_count and exc_count; counters wrap modulo 2^CNT_W.
PROTECT_R0, 0, when 1 a write-back to register 0 is suppressed; result still reported.

Ports:
clk  in  1  rising-edge clock shared with RF
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction word offered
instr_ready  out  1  block can accept this cycle
instr  in  32  MIPS instruction word
rr1  out  5  RF read register 1 (ALU A)
rr2  out  5  RF read register 2 (ALU B)
wr  out  5  RF write register
wr_en  out  1  RF write enable
sel  out  2  write-data mux select; constant 1 (ALU result)
mode  out  1  ALU mode; constant 1 (signed, compare enabled)
op  out  4  ALU opcode
shift_amp  out  32  zero-extended shamt
alu_result  in  32  ALU result
alu_overflow  in  1  ALU overflow
result  out  32  last retired ALU result (registered)
result_valid  out  1  1-cycle pulse, result updated
exc_overflow  out  1  1-cycle pulse, add/sub overflow, write suppressed
exc_illegal  out  1  1-cycle pulse, unsupported encoding
retired_count  out  CNT_W  instructions that wrote back
exc_count  out  CNT_W  overflow + illegal events

Behaviour:
- Reset (async, rst_n=0): state IDLE, instruction register 0, wr_en=0, result=0, all pulses 0, counters 0. Any in-flight instruction is dropped with no RF write. Deassertion is synchronised to clk.
- Decode: opcode[31:26] must be 0. funct 0x20→op 0000 add; 0x22→0001 sub; 0x24→0010 and; 0x25→0011 or; 0x00→0100 sll; 0x02→0101 srl; 0x03→0110 sra; 0x2C→0111 sgt; 0x2A→1000 slt. Any other opcode or funct is illegal.
- Operand routing: R-ops drive rr1=rs, rr2=rt. Shifts drive rr1=rt, rr2=rt. shift_amp={27'b0,shamt} for every op.
- Outputs rr1/rr2/op/shift_amp/wr are driven combinationally from the latched instruction register.
- FSM states:
  - IDLE: instr_ready=1. On handshake, latch instr. Legal instruction → READ. Illegal → ILL.
  - READ: one cycle. The RF samples rr1/rr2 at the closing edge. → EXEC.
  - EXEC: rd1/rd2 valid and ALU output settled. wr=rd. wr_en=1 unless (op is add or sub and alu_overflow=1) or (PROTECT_R0 and rd=0). At the closing edge:
    - result<=alu_result and result_valid pulses next cycle; result is updated on overflow too.
    - Overflow case: exc_overflow pulses, exc_count increments.
    - Otherwise: retired_count increments.
    - instr_ready=1 in EXEC. A handshake here latches the next instruction and goes to READ/ILL; otherwise → IDLE.
  - ILL: exc_illegal=1 for one cycle, exc_count increments, wr_en=0 → IDLE.
- Throughput: back-to-back, one instruction per 2 cycles. Latency from handshake to result_valid is 3 cycles.
- RAW hazard: the EXEC write and the next READ are separated by one edge, and the RF read samples after the write lands. No forwarding or stall is needed.
- wr_en is never 1 outside EXEC. instr_valid while instr_ready=0 is ignored; the source must hold the word.

Decomposition:
- Shared package alu_pkg holds the op codes (OP_ADD..OP_SLT), the funct constants, the R-type opcode, and the state enum.
- Sub-module alu_decoder (combinational instr→op/legal/operand-select), which the verifier can test standalone.

Test Plan:
1. RF init (r0=5, r1=100); instr 0x00010820 (add r1,r0,r1) → wr_en=1 with wr=1 in EXEC, result=105, result_valid 3 cycles after handshake, retired_count=1.
2. instr 0x00631820 (add r3,r3,r3; r3=2147483647) → alu_overflow=1, wr_en stays 0, exc_overflow pulse, r3 unchanged, exc_count=1.
3. instr 0x000B6843 (sra r13,r11,1; r11=-6) → rr1=11, shift_amp=1, result=-3 written to r13.
4. instr 0x014B702A (slt r14,r10,r11; -5,-6) → result=0. Follow back-to-back with sgt funct 0x2C on the same registers → result=1, accepted in EXEC, 2-cycle spacing.
5. instr 0x20010005 (addi) → exc_illegal pulse, no wr_en, returns to IDLE, next instruction accepted.
6. Assert rst_n=0 in EXEC of an add → wr_en drops immediately, no write, counters and result are 0 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, funct codes, FSM states and legality helper for the ALU issue controller
package alu_pkg;
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_SRA = 6'h03;
    localparam logic [5:0] F_SGT = 6'h2C;
    localparam logic [5:0] F_SLT = 6'h2A;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd6;
    localparam logic [3:0] OP_SGT = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_ILL} state_t;
    function automatic logic rtype_legal(input logic [31:0] w);
        return (w[31:26] == OPC_RTYPE) &&
               (w[5:0] inside {F_ADD, F_SUB, F_AND, F_OR, F_SLL, F_SRL, F_SRA, F_SGT, F_SLT});
    endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational R-type decode of an instruction word into ALU op, legality and shift operand routing
module alu_decoder
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  op,
    output logic        legal,
    output logic        shift
);
    always_comb begin
        op = OP_ADD;
        shift = 1'b0;
        legal = rtype_legal(instr);
        case (instr[5:0])
            F_SUB: op = OP_SUB;
            F_AND: op = OP_AND;
            F_OR:  op = OP_OR;
            F_SLL: begin op = OP_SLL; shift = 1'b1; end
            F_SRL: begin op = OP_SRL; shift = 1'b1; end
            F_SRA: begin op = OP_SRA; shift = 1'b1; end
            F_SGT: op = OP_SGT;
            F_SLT: op = OP_SLT;
            default: op = OP_ADD;
        endcase
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts R-type words, sequences RF read / ALU eval / write-back, flags exceptions and counts retirements
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter bit PROTECT_R0 = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic [4:0]       rr1,
    output logic [4:0]       rr2,
    output logic [4:0]       wr,
    output logic             wr_en,
    output logic [1:0]       sel,
    output logic             mode,
    output logic [3:0]       op,
    output logic [31:0]      shift_amp,
    input  logic [31:0]      alu_result,
    input  logic             alu_overflow,
    output logic [31:0]      result,
    output logic             result_valid,
    output logic             exc_overflow,
    output logic             exc_illegal,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] exc_count
);
    state_t      state, state_nx;
    logic [31:0] ir;
    logic [1:0]  rst_sync;
    logic        rst_n_s, ir_legal, ir_shift, take, in_exec, ovf;

    // Reset asserts immediately but releases only after two clean clock edges
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    assign rst_n_s = rst_sync[1];

    alu_decoder u_dec (.instr(ir), .op(op), .legal(ir_legal), .shift(ir_shift));

    assign rr1       = ir_shift ? ir[20:16] : ir[25:21];
    assign rr2       = ir[20:16];
    assign wr        = ir[15:11];
    assign shift_amp = {27'b0, ir[10:6]};
    assign sel       = 2'd1;
    assign mode      = 1'b1;

    always_comb begin
        instr_ready = rst_n_s && (state == S_IDLE || state == S_EXEC);
        take        = instr_valid && instr_ready;
        in_exec     = (state == S_EXEC) && ir_legal;
        ovf         = in_exec && alu_overflow && (op == OP_ADD || op == OP_SUB);
        wr_en       = in_exec && !ovf && !(PROTECT_R0 && ir[15:11] == 5'd0);
        exc_illegal = (state == S_ILL);
        state_nx    = (state == S_READ) ? S_EXEC :
                      take ? (rtype_legal(instr) ? S_READ : S_ILL) : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n_s)
        if (!rst_n_s) begin
            state         <= S_IDLE;
            ir            <= '0;
            result        <= '0;
            result_valid  <= 1'b0;
            exc_overflow  <= 1'b0;
            retired_count <= '0;
            exc_count     <= '0;
        end else begin
            state        <= state_nx;
            result_valid <= in_exec;
            exc_overflow <= ovf;
            if (take) ir <= instr;
            if (in_exec) result <= alu_result;
            if (in_exec && !ovf) retired_count <= retired_count + CNT_W'(1);
            if (ovf || state == S_ILL) exc_count <= exc_count + CNT_W'(1);
        end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: drives directed R-type words through a bench-side RF/ALU and checks against an architectural model
module tb_alu_issue_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0;
    logic        instr_ready, wr_en, mode, alu_overflow, result_valid, exc_overflow, exc_illegal;
    logic [31:0] instr = '0, shift_amp, alu_result, result;
    logic [4:0]  rr1, rr2, wr;
    logic [1:0]  sel;
    logic [3:0]  op;
    logic [15:0] retired_count, exc_count;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rr1(rr1), .rr2(rr2), .wr(wr), .wr_en(wr_en), .sel(sel), .mode(mode),
        .op(op), .shift_amp(shift_amp), .alu_result(alu_result), .alu_overflow(alu_overflow),
        .result(result), .result_valid(result_valid), .exc_overflow(exc_overflow),
        .exc_illegal(exc_illegal), .retired_count(retired_count), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [31:0] INIT [32] = '{0: 32'd5, 1: 32'd100, 3: 32'h7fffffff,
                                         10: 32'hfffffffb, 11: 32'hfffffffa, default: 32'd0};

    // Register file with registered read and ALU-sourced write port
    logic [31:0] rf [32] = INIT;
    logic [31:0] rd1 = '0, rd2 = '0;
    always @(posedge clk) begin
        if (wr_en) rf[wr] <= alu_result;
        rd1 <= rf[rr1];
        rd2 <= rf[rr2];
    end

    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (op)
            4'd0: begin alu_result = rd1 + rd2; alu_overflow = (rd1[31] == rd2[31]) && (alu_result[31] != rd1[31]); end
            4'd1: begin alu_result = rd1 - rd2; alu_overflow = (rd1[31] != rd2[31]) && (alu_result[31] != rd1[31]); end
            4'd2: alu_result = rd1 & rd2;
            4'd3: alu_result = rd1 | rd2;
            4'd4: alu_result = rd1 << shift_amp[4:0];
            4'd5: alu_result = rd1 >> shift_amp[4:0];
            4'd6: alu_result = $signed(rd1) >>> shift_amp[4:0];
            4'd7: alu_result = {31'b0, $signed(rd1) > $signed(rd2)};
            4'd8: alu_result = {31'b0, $signed(rd1) < $signed(rd2)};
            default: alu_result = '0;
        endcase
    end

    int pass_n = 0, tot_n = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    endtask

    // Per-cycle expectations filled in by the architectural model at each handshake
    bit        exp_rv [4096], exp_ovf [4096], exp_ill [4096], exp_we [4096];
    bit [31:0] exp_res [4096];
    bit [4:0]  exp_wr [4096];
    int        inc_ret [4096], inc_exc [4096];
    logic [31:0] am [32];

    task automatic model(input logic [31:0] w, input int h);
        logic [4:0]  rs = w[25:21], rt = w[20:16], rd = w[15:11], sh = w[10:6];
        logic [31:0] a = am[rs], b = am[rt], r = '0;
        bit          ok = (w[31:26] == 6'd0), ov = 1'b0;
        longint      s;
        case (w[5:0])
            6'h20: begin s = longint'($signed(a)) + longint'($signed(b)); r = s[31:0]; ov = s > 64'sd2147483647 || s < -64'sd2147483648; end
            6'h22: begin s = longint'($signed(a)) - longint'($signed(b)); r = s[31:0]; ov = s > 64'sd2147483647 || s < -64'sd2147483648; end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h00: r = b << sh;
            6'h02: r = b >> sh;
            6'h03: r = $signed(b) >>> sh;
            6'h2C: r = {31'b0, $signed(a) > $signed(b)};
            6'h2A: r = {31'b0, $signed(a) < $signed(b)};
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            exp_ill[h+1] = 1'b1;
            inc_exc[h+2]++;
        end else begin
            exp_we[h+2]  = !ov;
            exp_wr[h+2]  = rd;
            exp_rv[h+3]  = 1'b1;
            exp_res[h+3] = r;
            exp_ovf[h+3] = ov;
            if (ov) inc_exc[h+3]++;
            else begin inc_ret[h+3]++; am[rd] = r; end
        end
    endtask

    bit chk_on = 1'b0;
    int er = 0, ee = 0;
    always @(negedge clk) begin
        if (!rst_n) begin er = 0; ee = 0; end
        else begin er += inc_ret[cyc]; ee += inc_exc[cyc]; end
        if (chk_on) begin
            chk("result_valid", 32'(result_valid), 32'(exp_rv[cyc]));
            chk("exc_overflow", 32'(exc_overflow), 32'(exp_ovf[cyc]));
            chk("exc_illegal", 32'(exc_illegal), 32'(exp_ill[cyc]));
            chk("wr_en", 32'(wr_en), 32'(exp_we[cyc]));
            if (exp_we[cyc]) chk("wr", 32'(wr), 32'(exp_wr[cyc]));
            if (exp_rv[cyc]) chk("result", result, exp_res[cyc]);
            chk("retired_count", 32'(retired_count), 32'(er[15:0]));
            chk("exc_count", 32'(exc_count), 32'(ee[15:0]));
        end
    end

    task automatic issue(input logic [31:0] w, output int h);
        int n = 0;
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
        h = cyc;
        model(w, h);
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    localparam logic [31:0] STREAM [6] = '{32'h014B7824, 32'h00208022, 32'h00018900,
                                           32'h000B9702, 32'h00000021, 32'h01409825};
    logic [31:0] am_save [32];
    int h, h2;

    initial begin
        am = INIT;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_result", result, 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_retired", 32'(retired_count), 32'd0);
        chk("rst_exc", 32'(exc_count), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("sel", 32'(sel), 32'd1);
        chk("mode", 32'(mode), 32'd1);
        chk_on = 1'b1;
        // add r1,r0,r1
        issue(32'h00010820, h);
        repeat (3) @(negedge clk);
        #1;
        chk("t1_result", result, 32'd105);
        chk("t1_rv", 32'(result_valid), 32'd1);
        chk("t1_retired", 32'(retired_count), 32'd1);
        chk("t1_rf1", rf[1], 32'd105);
        // add r3,r3,r3 overflows
        issue(32'h00631820, h);
        repeat (3) @(negedge clk);
        #1;
        chk("t2_exc_ovf", 32'(exc_overflow), 32'd1);
        chk("t2_exc_count", 32'(exc_count), 32'd1);
        chk("t2_result", result, 32'hfffffffe);
        chk("t2_rf3", rf[3], 32'h7fffffff);
        // sra r13,r11,1
        issue(32'h000B6843, h);
        @(negedge clk);
        #1;
        chk("t3_rr1", 32'(rr1), 32'd11);
        chk("t3_shamt", shift_amp, 32'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("t3_result", result, 32'hfffffffd);
        chk("t3_rf13", rf[13], 32'hfffffffd);
        // slt then sgt back-to-back
        issue(32'h014B702A, h);
        @(negedge clk);
        issue(32'h014B702C, h2);
        chk("t4_spacing", 32'(h2 - h), 32'd2);
        @(negedge clk);
        #1;
        chk("t4_slt", result, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("t4_sgt", result, 32'd1);
        chk("t4_rf14", rf[14], 32'd1);
        // addi is illegal, followed by a mixed back-to-back stream
        issue(32'h20010005, h);
        @(negedge clk);
        #1;
        chk("t5_ill", 32'(exc_illegal), 32'd1);
        chk("t5_wr_en", 32'(wr_en), 32'd0);
        for (int i = 0; i < 6; i++) begin
            issue(STREAM[i], h2);
            if (i == 0) chk("t5_accept", 32'(h2 - h), 32'd2);
        end
        repeat (6) @(negedge clk);
        // reset in EXEC of an add drops the write
        am_save = am;
        issue(32'h00010820, h);
        repeat (2) @(negedge clk);
        #1;
        chk("t6_exec_we", 32'(wr_en), 32'd1);
        chk_on = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_we_drop", 32'(wr_en), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        am = am_save;
        repeat (4) @(negedge clk);
        #1;
        chk("t6_rf1", rf[1], 32'd105);
        chk("t6_result", result, 32'd0);
        chk("t6_retired", 32'(retired_count), 32'd0);
        chk("t6_exc", 32'(exc_count), 32'd0);
        chk_on = 1'b1;
        issue(32'h00208022, h);
        repeat (4) @(negedge clk);
        #1;
        chk("t6_post_retired", 32'(retired_count), 32'd1);
        chk("t6_post_rf16", rf[16], 32'd100);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
